// File: rtl/led7seg_pkg.sv
// Shared definitions for the multiplexed 7-segment driver: scan states,
// the blank segment pattern and the hex-to-segment decode table.
package led7seg_pkg;

    // Active-high segment pattern for a dark digit; pin polarity is applied later
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    // Segment order {a,b,c,d,e,f,g}, active-high
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'h7E;
            4'h1:    code = 7'h30;
            4'h2:    code = 7'h6D;
            4'h3:    code = 7'h79;
            4'h4:    code = 7'h33;
            4'h5:    code = 7'h5B;
            4'h6:    code = 7'h5F;
            4'h7:    code = 7'h70;
            4'h8:    code = 7'h7F;
            4'h9:    code = 7'h7B;
            4'hA:    code = 7'h77;
            4'hB:    code = 7'h1F;
            4'hC:    code = 7'h4E;
            4'hD:    code = 7'h3D;
            4'hE:    code = 7'h4F;
            default: code = 7'h47;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/led7seg_prescaler.sv
// Digit-slot timer: counts 0..PRESCALE-1, flags the last cycle of the slot
// (wrap) and the last cycle of the anti-ghost blanking window.
module led7seg_prescaler #(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic wrap,
    output logic blank_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (!enable || wrap) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign wrap       = enable && (cnt_reg == CW'(PRESCALE - 1));
    assign blank_done = enable && (cnt_reg == CW'(BLANK_CYC - 1));

endmodule

// File: rtl/led7seg_scan.sv
// Time-multiplexed 7-segment bank driver with frame-synchronous double
// buffering, inter-digit blanking, leading-zero blanking and decimal points.
module led7seg_scan
    import led7seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 50000,
    parameter int BLANK_CYC   = 2,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]     SEG_INV  = {7{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] AN_INV = {DIGITS{DIG_ACT_LOW}};

    logic                       wrap;
    logic                       blank_done;
    logic                       frame_edge;
    logic                       restart;
    logic                       enable_d_reg;
    logic [IW-1:0]              idx_reg;
    scan_state_t                state_reg, state_next;
    logic [DIGITS-1:0][3:0]     pending_reg, shadow_reg;
    logic [DIGITS-1:0]          pending_dp_reg, shadow_dp_reg;
    logic [DIGITS-1:0]          lead_zero;
    logic                       digit_on;
    logic [6:0]                 seg_next;
    logic                       dp_next;
    logic [DIGITS-1:0]          an_next;
    logic [6:0]                 seg_reg;
    logic                       dp_reg;
    logic [DIGITS-1:0]          an_reg;
    logic                       frame_tick_reg;

    led7seg_prescaler #(
        .PRESCALE  (PRESCALE),
        .BLANK_CYC (BLANK_CYC)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wrap       (wrap),
        .blank_done (blank_done)
    );

    assign frame_edge = wrap && (idx_reg == IDX_LAST);
    assign restart    = enable && !enable_d_reg;

    // Digit gi is a leading zero when it and every more-significant digit are 0
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign lead_zero[gi] = ~|shadow_reg[DIGITS-1:gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BLANK: if (blank_done) state_next = ST_ON;
            ST_ON:    if (wrap)       state_next = ST_BLANK;
            default:                  state_next = ST_BLANK;
        endcase
        if (!enable) begin
            state_next = ST_BLANK;
        end
    end

    always_comb begin
        digit_on = (state_reg == ST_ON) && enable;
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        an_next  = '0;
        if (digit_on) begin
            an_next = DIGITS'(1) << idx_reg;
            dp_next = shadow_dp_reg[idx_reg];
            if (!(lzb && (idx_reg != '0) && lead_zero[idx_reg])) begin
                seg_next = hex_to_seg(shadow_reg[idx_reg]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_BLANK;
            enable_d_reg   <= 1'b0;
            idx_reg        <= '0;
            pending_reg    <= '0;
            pending_dp_reg <= '0;
            shadow_reg     <= '0;
            shadow_dp_reg  <= '0;
            frame_tick_reg <= 1'b0;
            seg_reg        <= SEG_OFF ^ SEG_INV;
            dp_reg         <= SEG_ACT_LOW;
            an_reg         <= AN_INV;
        end else begin
            state_reg    <= state_next;
            enable_d_reg <= enable;
            if (load) begin
                pending_reg    <= data;
                pending_dp_reg <= dp_in;
            end
            if (!enable) begin
                idx_reg <= '0;
            end else if (wrap) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            // Non-blocking read of pending: a load in this same cycle waits a frame
            if (frame_edge || restart) begin
                shadow_reg    <= pending_reg;
                shadow_dp_reg <= pending_dp_reg;
            end
            frame_tick_reg <= frame_edge;
            seg_reg        <= seg_next ^ SEG_INV;
            dp_reg         <= dp_next ^ SEG_ACT_LOW;
            an_reg         <= an_next ^ AN_INV;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_led7seg_scan.sv
// Scoreboard bench for led7seg_scan: stimulus queues the expected pin values
// per digit slot, a monitor compares them as each digit lights up.
module tb_led7seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int n_pass = 0;
    int n_chk  = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t exp_q[$];

    // Active-low segment codes for hex 0..F
    localparam logic [6:0] SEG_AL [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    always #5 clk = ~clk;

    led7seg_scan #(
        .DIGITS      (4),
        .PRESCALE    (8),
        .BLANK_CYC   (2),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .data       (data),
        .dp_in      (dp_in),
        .lzb        (lzb),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Queue one frame of expected slots; blank_mask marks digits expected dark
    task automatic push_frame(input logic [15:0] word, input logic [3:0] dpv, input logic [3:0] blank_mask);
        slot_t s;
        for (int i = 0; i < 4; i++) begin
            s.an  = ~(4'b0001 << i);
            s.seg = blank_mask[i] ? 7'h7F : SEG_AL[word[i*4 +: 4]];
            s.dp  = ~dpv[i];
            exp_q.push_back(s);
        end
    endtask

    task automatic load_word(input logic [15:0] word, input logic [3:0] dpv);
        data  = word;
        dp_in = dpv;
        load  = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        $display("load data=%h dp_in=%b", word, dpv);
    endtask

    task automatic wait_tick();
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (frame_tick) break;
        end
        chk("frame_tick_wait", 32'(k < 100), 32'd1);
    endtask

    task automatic drain();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a new digit lighting up is one transaction
    initial begin
        logic [3:0] prev_an;
        slot_t      e;
        prev_an = 4'hF;
        forever begin
            @(negedge clk);
            if (an !== prev_an && an !== 4'hF && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("slot an=%h seg=%h dp=%b (expect an=%h seg=%h dp=%b)",
                         an, seg, dp, e.an, e.seg, e.dp);
                chk("slot_an", 32'(an), 32'(e.an));
                chk("slot_seg", 32'(seg), 32'(e.seg));
                chk("slot_dp", 32'(dp), 32'(e.dp));
            end
            prev_an = an;
        end
    end

    initial begin
        int         ticks;
        logic [3:0] exp_an;

        // 1: reset values, then the free-running scan pattern
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ticks = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            exp_an = ((k % 8) < 2) ? 4'hF : ~(4'b0001 << (k / 8));
            chk("scan_an", 32'(an), 32'(exp_an));
            if (frame_tick) begin
                ticks++;
                chk("tick_pos", 32'(k), 32'd31);
            end
        end
        chk("tick_count", 32'(ticks), 32'd1);

        // 2: basic display with a decimal point on digit 2
        load_word(16'h1234, 4'b0100);
        wait_tick();
        push_frame(16'h1234, 4'b0100, 4'b0000);
        wait_tick();
        drain();

        // 3: leading-zero blanking on and off
        load_word(16'h00A0, 4'b0000);
        lzb = 1'b1;
        wait_tick();
        push_frame(16'h00A0, 4'b0000, 4'b1100);
        wait_tick();
        drain();
        lzb = 1'b0;
        push_frame(16'h00A0, 4'b0000, 4'b0000);
        wait_tick();
        drain();

        // 4a: load landing in the frame-boundary cycle shows one frame late
        repeat (31) @(posedge clk);
        #1;
        data = 16'hBEEF;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("tick_on_load_cycle", 32'(frame_tick), 32'd1);
        push_frame(16'h00A0, 4'b0000, 4'b0000);
        wait_tick();
        drain();
        push_frame(16'hBEEF, 4'b0000, 4'b0000);
        wait_tick();
        drain();

        // 4b: two loads mid-frame; current frame untouched, last load wins
        push_frame(16'hBEEF, 4'b0000, 4'b0000);
        repeat (5) @(posedge clk);
        #1;
        load_word(16'h1111, 4'b0000);
        repeat (10) @(posedge clk);
        #1;
        load_word(16'h9876, 4'b0000);
        wait_tick();
        drain();
        push_frame(16'h9876, 4'b0000, 4'b0000);
        wait_tick();
        drain();

        // 5: disable mid-scan, load while dark, restart from slot 0
        repeat (12) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            load = (i == 3);
            if (i == 3) data = 16'h5555;
            @(posedge clk); #1;
            chk("dis_an", 32'(an), 32'hF);
            chk("dis_seg", 32'(seg), 32'h7F);
            chk("dis_tick", 32'(frame_tick), 32'd0);
        end
        load = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        chk("restart_dark0", 32'(an), 32'hF);
        @(posedge clk); #1;
        chk("restart_dark1", 32'(an), 32'hF);
        @(posedge clk); #1;
        chk("restart_an", 32'(an), 32'hE);
        chk("restart_seg", 32'(seg), 32'h24);

        // 6: asynchronous reset in the middle of an ON slot
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_an", 32'(an), 32'hF);
        chk("async_rst_dp", 32'(dp), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_frame(16'h0000, 4'b0000, 4'b0000);
        wait_tick();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
